// File: rtl/usb_in_packetizer.sv
// rtl/usb_in_packetizer.sv - byte stream to FX2 stream-IN packetizer with staging register and FWFT FIFO
// Optional PKT_STATS_EN macro enables the pkt_sent / flush_cnt counters.
`timescale 1ns/1ps
module usb_in_packetizer #(
  parameter int DEPTH_LOG2    = 4,
  parameter int MAX_PKT       = 512,
  parameter int FLUSH_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [7:0]            m_data,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic [15:0]           pkt_sent,
  output logic [7:0]            flush_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = $clog2(FLUSH_TIMEOUT);

  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [8:0]          mem_q [DEPTH];
  logic [7:0]          stg_data_q, stg_data_d;
  logic                stg_last_q, stg_last_d;
  logic                stg_valid_q, stg_valid_d;
  logic [15:0]         pkt_cnt_q, pkt_cnt_d;
  logic [TW-1:0]       idle_q, idle_d;

  logic       full, empty, accept, push, pop, pkt_wrap, timeout_hit, new_last;
  logic [8:0] head, push_word;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == (DEPTH_LOG2+1)'(DEPTH));
  assign empty   = (wr_ptr_q == rd_ptr_q);
  // Occupancy is the registered value: a pop in the same cycle never frees room for a push.
  assign s_ready = !reset && (!stg_valid_q || !full);
  assign accept  = s_valid && s_ready;

  assign pkt_wrap    = (pkt_cnt_q == 16'(MAX_PKT-1));
  assign new_last    = s_last || pkt_wrap;
  assign timeout_hit = !accept && stg_valid_q && !stg_last_q && (idle_q == TW'(FLUSH_TIMEOUT-1));
  assign push        = stg_valid_q && !full && (stg_last_q || accept || timeout_hit);
  assign pop         = !empty && m_ready;
  assign push_word   = {stg_last_q || timeout_hit, stg_data_q};

  assign head    = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign m_valid = !empty;
  assign m_data  = m_valid ? head[7:0] : 8'h00;
  assign m_last  = m_valid && head[8];

  always_comb begin
    stg_data_d  = stg_data_q;
    stg_last_d  = stg_last_q;
    stg_valid_d = stg_valid_q;
    pkt_cnt_d   = pkt_cnt_q;
    idle_d      = idle_q;
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    if (accept) begin
      stg_data_d  = s_data;
      stg_last_d  = new_last;
      stg_valid_d = 1'b1;
      idle_d      = '0;
      pkt_cnt_d   = new_last ? 16'd0 : pkt_cnt_q + 16'd1;
    end else begin
      // Timeout retro-tags the waiting byte; it then drains like any last byte.
      if (timeout_hit) begin
        stg_last_d = 1'b1;
        idle_d     = '0;
        pkt_cnt_d  = 16'd0;
      end else if (stg_valid_q && !stg_last_q) begin
        idle_d = idle_q + TW'(1);
      end
      if (push) stg_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      stg_data_q  <= 8'h00;
      stg_last_q  <= 1'b0;
      stg_valid_q <= 1'b0;
      pkt_cnt_q   <= 16'd0;
      idle_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      stg_data_q  <= stg_data_d;
      stg_last_q  <= stg_last_d;
      stg_valid_q <= stg_valid_d;
      pkt_cnt_q   <= pkt_cnt_d;
      idle_q      <= idle_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_word;
  end

`ifdef PKT_STATS_EN
  logic [15:0] pkt_sent_q;
  logic [7:0]  flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_sent_q  <= 16'd0;
      flush_cnt_q <= 8'd0;
    end else begin
      if (pop && head[8]) pkt_sent_q <= pkt_sent_q + 16'd1;
      if (timeout_hit && flush_cnt_q != 8'hFF) flush_cnt_q <= flush_cnt_q + 8'd1;
    end
  end

  assign pkt_sent  = pkt_sent_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign pkt_sent  = 16'd0;
  assign flush_cnt = 8'd0;
`endif

endmodule
